hb_decim_by2: RTL
=================

// Module: hb_decim_by2
// PURPOSE
//  11-tap half-band decimate-by-2 stage of the Rx decimation chain; consumes full-rate samples, emits every 2nd filtered sample.
//  Center tap is a fixed x0.5 (256 in Q9) on the even-phase path; the odd phase uses three symmetric coefficient pairs.
//  Sits after the E0 center-tap gain stage; output feeds the next decimation stage at half rate.
// PARAMETERS
//  IN_W   10   signed input sample width
//  OUT_W  10   signed output width after rounding/saturation
//  C0     6    Q9 coeff, taps 0/10
//  C1     -38  Q9 coeff, taps 2/8
//  C2     160  Q9 coeff, taps 4/6 (center tap 5 fixed = 256; taps 1,3,7,9 = 0; DC gain = 512)
//  SHIFT  9    right shift applied after accumulation (Q9 -> integer)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-high reset
//  sync_clr   in   1      synchronous clear of history, phase, pipeline
//  in_valid   in   1      in_data accepted on this edge when high
//  in_data    in   IN_W   signed input sample
//  out_valid  out  1      one-cycle pulse: out_data valid
//  out_data   out  OUT_W  signed decimated sample
// BEHAVIOUR
//  - Reset (rst=1, async): x[0..10], phase, pipeline regs/valids = 0; out_valid=0, out_data=0. Takes effect immediately; in-flight outputs dropped.
//  - sync_clr=1: same clear on the clock edge; has priority over in_valid (sample discarded).
//  - History: on in_valid, x[0]<=in_data, x[k]<=x[k-1] for k=1..10; phase toggles (first sample after reset/clear is phase 0).
//  - Output trigger: edge E accepts a sample while phase==1 -> fire pulse enters pipeline; phase-0 accepts produce nothing.
//  - Pipeline (fire-tagged valid bit per stage, no stall, no backpressure):
//      E+1: p0=x[0]+x[10], p1=x[2]+x[8], p2=x[4]+x[6] (IN_W+1 bits), c=x[5]
//      E+2: m0=C0*p0, m1=C1*p1, m2=C2*p2, m3=c<<<8
//      E+3: acc=m0+m1+m2+m3 (20-bit signed, no overflow); r=(acc+2^(SHIFT-1))>>>SHIFT (arithmetic, round half up);
//           out_data=sat(r to OUT_W: >2^(OUT_W-1)-1 -> max, <-2^(OUT_W-1) -> min); out_valid=1
//  - out_valid is high exactly the cycle after edge E+3; out_data holds its value until the next pulse.
//  - in_valid may be held high continuously: max rate 1 output per 2 cycles; gaps in in_valid pause phase/history only.
//  - History starts as zeros: outputs emitted from the 1st phase-1 sample (no priming suppression).
//  - rst or sync_clr between E and E+3 cancels that pending output.
// TESTING
//  1 Impulse on phase-0: in_valid=1 continuous, in_data=100 then zeros -> out_data 0,0,50,0,0,0 (50 on 3rd pulse).
//  2 Impulse on phase-1: 0,100, then zeros -> out_data 1,-7,31,31,-7,1, then 0.
//  3 DC: constant 100 for >=12 samples -> steady-state out_data=100; pulses spaced exactly 2 cycles apart.
//  4 Saturation: fill taps 0,4,5,6,10=511 and taps 2,8=-512 -> acc=339380, r=663 -> out_data=511; mirrored signs -> -512.
//  5 Latency/gaps: in_valid pattern 1,0,0,1 -> single out_valid pulse exactly 4 cycles after the 2nd accept edge; no pulse on the 1st.
//  6 Mid-flight reset: assert rst (or sync_clr) 1 cycle after a phase-1 accept -> no out_valid; next output uses zeroed history and phase 0.

Source files
------------

// File: rtl/hb_decim_by2.sv
// hb_decim_by2: 11-tap half-band decimate-by-2 filter stage.
//
// Consumes one full-rate sample per accepted in_valid. It emits one filtered sample for every
// second accepted input, the one accepted while the phase is odd. The centre tap is a fixed
// 0.5 implemented as a shift. The odd-index taps are zero. The even-index taps form three
// symmetric pairs, so each pair is pre-added before the multiply.
//
// Pipeline: accept edge E tags a fire bit. The tap sums are registered at E+1, the products
// at E+2, and the rounded, saturated result at E+3. out_valid is high for the cycle after
// E+3. The pipeline has no stall and no backpressure.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   sync_clr   synchronous clear of history, phase and pipeline (wins over in_valid)
//   in_valid   in_data accepted on this edge when high
//   in_data    signed input sample, IN_W bits
//   out_valid  one-cycle pulse marking a new out_data
//   out_data   signed decimated sample, OUT_W bits, held between pulses
module hb_decim_by2 #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 10,
  parameter int          C0    = 6,
  parameter int          C1    = -38,
  parameter int          C2    = 160,
  parameter int unsigned SHIFT = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync_clr,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data
);

  localparam int unsigned ACC_W = 20;
  localparam int unsigned P_W   = IN_W + 1;
  localparam int unsigned TAPS  = 11;

  localparam logic signed [ACC_W-1:0] C0_W    = ACC_W'(C0);
  localparam logic signed [ACC_W-1:0] C1_W    = ACC_W'(C1);
  localparam logic signed [ACC_W-1:0] C2_W    = ACC_W'(C2);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (SHIFT - 1));
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(1 << (OUT_W - 1)));

  // Sample history; x_q[0] is the newest sample.
  logic signed [IN_W-1:0]  x_q [TAPS];
  logic                    phase_q;

  // Stage 0: fire tag for the accept edge.
  logic                    fire_q;

  // Stage 1: symmetric pre-adds and the centre sample.
  logic                    s1_valid_q;
  logic signed [P_W-1:0]   p0_q, p1_q, p2_q;
  logic signed [IN_W-1:0]  c_q;

  // Stage 2: products.
  logic                    s2_valid_q;
  logic signed [ACC_W-1:0] m0_q, m1_q, m2_q, m3_q;

  // Stage 3 combinational: sum, round half up, saturate.
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] sat;

  always_comb begin
    acc = m0_q + m1_q + m2_q + m3_q;
    // Adding half an LSB, then arithmetic shifting, rounds half toward +inf.
    rnd = (acc + RND) >>> SHIFT;
    sat = rnd;
    if (rnd > OUT_MAX) begin
      sat = OUT_MAX;
    end else if (rnd < OUT_MIN) begin
      sat = OUT_MIN;
    end
  end

  // History and phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      phase_q <= 1'b0;
    end else if (sync_clr) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
      phase_q <= 1'b0;
    end else if (in_valid) begin
      x_q[0] <= in_data;
      for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
      phase_q <= ~phase_q;
    end
  end

  // Valid tags. A clear drops every in-flight output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_valid  <= 1'b0;
    end else if (sync_clr) begin
      fire_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      fire_q     <= in_valid & phase_q;
      s1_valid_q <= fire_q;
      s2_valid_q <= s1_valid_q;
      out_valid  <= s2_valid_q;
    end
  end

  // Data path. Registers load only when their stage carries a fire tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_q     <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      c_q      <= '0;
      m0_q     <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      m3_q     <= '0;
      out_data <= '0;
    end else if (sync_clr) begin
      p0_q     <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      c_q      <= '0;
      m0_q     <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      m3_q     <= '0;
      out_data <= '0;
    end else begin
      if (fire_q) begin
        p0_q <= P_W'(x_q[0]) + P_W'(x_q[10]);
        p1_q <= P_W'(x_q[2]) + P_W'(x_q[8]);
        p2_q <= P_W'(x_q[4]) + P_W'(x_q[6]);
        c_q  <= x_q[5];
      end
      if (s1_valid_q) begin
        m0_q <= C0_W * ACC_W'(p0_q);
        m1_q <= C1_W * ACC_W'(p1_q);
        m2_q <= C2_W * ACC_W'(p2_q);
        // The centre tap is exactly half of unity gain.
        m3_q <= ACC_W'(c_q) <<< (SHIFT - 1);
      end
      if (s2_valid_q) begin
        out_data <= OUT_W'(sat);
      end
    end
  end

endmodule
